// File: rtl/cache_pkg.sv
// Shared types and geometry helpers for the N-way set-associative word cache.
package cache_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOOKUP = 3'd1,
    MEM_RD = 3'd2,
    MEM_WR = 3'd3,
    RESP   = 3'd4
  } state_e;

  function automatic int calc_idx_w(input int sets);
    return $clog2(sets);
  endfunction

  function automatic int calc_tag_w(input int addr_w, input int sets);
    return addr_w - $clog2(sets);
  endfunction

  function automatic int calc_way_w(input int ways);
    return $clog2(ways);
  endfunction

endpackage

// File: rtl/cache_lru.sv
// True-LRU age tracking per set: ages form a permutation of 0..WAYS-1, oldest = WAYS-1.
module cache_lru
  import cache_pkg::*;
#(
  parameter int WAYS = 4,
  parameter int SETS = 16,
  localparam int IDX_W = calc_idx_w(SETS),
  localparam int WAY_W = calc_way_w(WAYS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] idx_i,
  input  logic [WAYS-1:0]  valid_i,
  output logic [WAY_W-1:0] victim_o,
  input  logic             touch_i,
  input  logic [WAY_W-1:0] touch_way_i
);

  localparam logic [WAY_W-1:0] AGE_ONE = WAY_W'(1);
  localparam logic [WAY_W-1:0] OLDEST  = WAY_W'(WAYS - 1);

  logic [WAY_W-1:0] age_q [SETS][WAYS];
  logic [WAY_W-1:0] inv_way_s;
  logic [WAY_W-1:0] old_way_s;
  logic [WAY_W-1:0] touch_age_s;

  assign touch_age_s = age_q[idx_i][touch_way_i];

  // Victim: lowest-index invalid way, else the way holding the oldest age
  always_comb begin
    inv_way_s = '0;
    old_way_s = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      inv_way_s = valid_i[w] ? inv_way_s : WAY_W'(w);
      old_way_s = (age_q[idx_i][w] == OLDEST) ? WAY_W'(w) : old_way_s;
    end
    victim_o = (&valid_i) ? old_way_s : inv_way_s;
  end

  // Age update: younger-than-touched ways age by one, touched way becomes newest
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < SETS; s++) begin
        for (int w = 0; w < WAYS; w++) begin
          age_q[s][w] <= WAY_W'(w);
        end
      end
    end else if (touch_i) begin
      for (int w = 0; w < WAYS; w++) begin
        if (WAY_W'(w) == touch_way_i) begin
          age_q[idx_i][w] <= '0;
        end else if (age_q[idx_i][w] < touch_age_s) begin
          age_q[idx_i][w] <= age_q[idx_i][w] + AGE_ONE;
        end else begin
          age_q[idx_i][w] <= age_q[idx_i][w];
        end
      end
    end
  end

endmodule

// File: rtl/cache_nway.sv
// N-way set-associative write-through / write-allocate word cache with true-LRU
// replacement, valid/ready request side, held memory handshake and saturating stats.
module cache_nway
  import cache_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int WAYS   = 4,
  parameter int SETS   = 16,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wr,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_hit,
  output logic              mem_req,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [CNT_W-1:0]  hit_count,
  output logic [CNT_W-1:0]  miss_count
);

  localparam int IDX_W = calc_idx_w(SETS);
  localparam int TAG_W = calc_tag_w(ADDR_W, SETS);
  localparam int WAY_W = calc_way_w(WAYS);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_ONE;
  endfunction

  state_e            state_q;
  logic              wr_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              req_ready_q, resp_valid_q, resp_hit_q, mem_req_q, mem_wr_q;
  logic [DATA_W-1:0] resp_rdata_q, mem_wdata_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [CNT_W-1:0]  hit_cnt_q, miss_cnt_q;

  logic [WAYS-1:0]   valid_q [SETS];
  logic [TAG_W-1:0]  tag_q   [SETS][WAYS];
  logic [DATA_W-1:0] data_q  [SETS][WAYS];

  logic [IDX_W-1:0]  idx_s;
  logic [TAG_W-1:0]  tag_s;
  logic [WAYS-1:0]   match_s;
  logic              hit_s;
  logic [WAY_W-1:0]  hit_way_s;
  logic [DATA_W-1:0] hit_data_s;
  logic [WAY_W-1:0]  victim_s;
  logic              fill_s;
  logic [WAY_W-1:0]  fill_way_s;
  logic [DATA_W-1:0] fill_data_s;
  logic              touch_s;
  logic [WAY_W-1:0]  touch_way_s;

  assign idx_s = addr_q[IDX_W-1:0];
  assign tag_s = addr_q[ADDR_W-1:IDX_W];

  // Parallel tag compare across the ways of the addressed set
  always_comb begin
    hit_way_s  = '0;
    hit_data_s = '0;
    for (int w = 0; w < WAYS; w++) begin
      match_s[w] = valid_q[idx_s][w] && (tag_q[idx_s][w] == tag_s);
      hit_way_s  = match_s[w] ? WAY_W'(w) : hit_way_s;
      hit_data_s = match_s[w] ? data_q[idx_s][w] : hit_data_s;
    end
    hit_s = |match_s;
  end

  // Array write and LRU touch control: write hit/miss in LOOKUP, read fill on ack
  always_comb begin
    fill_s      = 1'b0;
    fill_way_s  = victim_s;
    fill_data_s = wdata_q;
    touch_s     = 1'b0;
    touch_way_s = victim_s;
    case (state_q)
      LOOKUP: begin
        if (hit_s) begin
          touch_s     = 1'b1;
          touch_way_s = hit_way_s;
          fill_s      = wr_q;
          fill_way_s  = hit_way_s;
        end else begin
          touch_s = wr_q;
          fill_s  = wr_q;
        end
      end
      MEM_RD: begin
        if (mem_ack) begin
          fill_s      = 1'b1;
          fill_data_s = mem_rdata;
          touch_s     = 1'b1;
        end else begin
          fill_s  = 1'b0;
          touch_s = 1'b0;
        end
      end
      default: begin
        fill_s  = 1'b0;
        touch_s = 1'b0;
      end
    endcase
  end

  cache_lru #(
    .WAYS(WAYS),
    .SETS(SETS)
  ) u_lru (
    .clk        (clk),
    .rst        (rst),
    .idx_i      (idx_s),
    .valid_i    (valid_q[idx_s]),
    .victim_o   (victim_s),
    .touch_i    (touch_s),
    .touch_way_i(touch_way_s)
  );

  // Valid bits are the only array state that must clear on reset
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
      end
    end else if (fill_s) begin
      valid_q[idx_s][fill_way_s] <= 1'b1;
    end
  end

  // Tag and data storage
  always_ff @(posedge clk) begin
    if (fill_s) begin
      tag_q[idx_s][fill_way_s]  <= tag_s;
      data_q[idx_s][fill_way_s] <= fill_data_s;
    end
  end

  // Request/memory FSM with registered handshake, response and counter outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      wr_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_hit_q   <= 1'b0;
      resp_rdata_q <= '0;
      mem_req_q    <= 1'b0;
      mem_wr_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      hit_cnt_q    <= '0;
      miss_cnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          resp_valid_q <= 1'b0;
          if (req_valid) begin
            wr_q        <= req_wr;
            addr_q      <= req_addr;
            wdata_q     <= req_wdata;
            req_ready_q <= 1'b0;
            state_q     <= LOOKUP;
          end
        end
        LOOKUP: begin
          resp_hit_q <= hit_s;
          if (hit_s) begin
            hit_cnt_q <= sat_inc(hit_cnt_q);
          end else begin
            miss_cnt_q <= sat_inc(miss_cnt_q);
          end
          if (!wr_q && hit_s) begin
            resp_rdata_q <= hit_data_s;
            resp_valid_q <= 1'b1;
            state_q      <= RESP;
          end else begin
            mem_req_q   <= 1'b1;
            mem_wr_q    <= wr_q;
            mem_addr_q  <= addr_q;
            mem_wdata_q <= wdata_q;
            state_q     <= wr_q ? MEM_WR : MEM_RD;
          end
        end
        MEM_RD: begin
          if (mem_ack) begin
            mem_req_q    <= 1'b0;
            resp_rdata_q <= mem_rdata;
            resp_hit_q   <= 1'b0;
            resp_valid_q <= 1'b1;
            state_q      <= RESP;
          end
        end
        MEM_WR: begin
          if (mem_ack) begin
            mem_req_q    <= 1'b0;
            resp_rdata_q <= wdata_q;
            resp_valid_q <= 1'b1;
            state_q      <= RESP;
          end
        end
        RESP: begin
          resp_valid_q <= 1'b0;
          req_ready_q  <= 1'b1;
          state_q      <= IDLE;
        end
        default: begin
          resp_valid_q <= 1'b0;
          req_ready_q  <= 1'b1;
          mem_req_q    <= 1'b0;
          state_q      <= IDLE;
        end
      endcase
    end
  end

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_hit   = resp_hit_q;
  assign mem_req    = mem_req_q;
  assign mem_wr     = mem_wr_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign hit_count  = hit_cnt_q;
  assign miss_count = miss_cnt_q;

endmodule

// File: tb/tb_cache_nway.sv
// Scoreboard bench for cache_nway: timestamp-LRU reference model, scripted backing memory.
module tb_cache_nway;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int NW = 4;
  localparam int NS = 16;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_wr = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_wdata = '0;
  logic          resp_valid;
  logic [DW-1:0] resp_rdata;
  logic          resp_hit;
  logic          mem_req;
  logic          mem_wr;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_ack = 1'b0;
  logic [DW-1:0] mem_rdata = '0;
  logic [CW-1:0] hit_count;
  logic [CW-1:0] miss_count;

  always #5 clk = ~clk;

  cache_nway #(
    .ADDR_W(AW), .DATA_W(DW), .WAYS(NW), .SETS(NS), .CNT_W(CW)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_hit(resp_hit),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .hit_count(hit_count), .miss_count(miss_count)
  );

  typedef struct packed {
    logic [DW-1:0] rdata;
    logic          hit;
  } exp_t;

  exp_t sb_q[$];
  int   total = 0;
  int   bad   = 0;

  bit            m_valid [NS][NW];
  logic [27:0]   m_tag   [NS][NW];
  logic [DW-1:0] m_data  [NS][NW];
  int            m_stamp [NS][NW];
  int            m_time = 0;
  int            exp_hits = 0;
  int            exp_miss = 0;
  logic [DW-1:0] mem_model [logic [AW-1:0]];

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] mem_read(input logic [AW-1:0] a);
    if (mem_model.exists(a)) return mem_model[a];
    else return (a * 32'h9E37_79B9) ^ 32'h1357_2468;
  endfunction

  task automatic model_reset();
    for (int s = 0; s < NS; s++)
      for (int w = 0; w < NW; w++) begin
        m_valid[s][w] = 1'b0;
        m_stamp[s][w] = 0;
      end
    exp_hits = 0;
    exp_miss = 0;
    sb_q.delete();
  endtask

  task automatic model_access(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                              output logic hit, output logic [DW-1:0] rd);
    int s, w, v;
    s   = int'(a[3:0]);
    hit = 1'b0;
    w   = 0;
    for (int i = 0; i < NW; i++)
      if (m_valid[s][i] && m_tag[s][i] == a[31:4]) begin hit = 1'b1; w = i; end
    if (!hit) begin
      v = -1;
      for (int i = NW - 1; i >= 0; i--) if (!m_valid[s][i]) v = i;
      if (v < 0) begin
        v = 0;
        for (int i = 1; i < NW; i++) if (m_stamp[s][i] < m_stamp[s][v]) v = i;
      end
      w = v;
    end
    m_time++;
    m_stamp[s][w] = m_time;
    m_valid[s][w] = 1'b1;
    m_tag[s][w]   = a[31:4];
    if (wr) begin
      m_data[s][w] = wd;
      mem_model[a] = wd;
    end else if (!hit) begin
      m_data[s][w] = mem_read(a);
    end
    rd = m_data[s][w];
    if (hit) exp_hits = (exp_hits < 15) ? exp_hits + 1 : 15;
    else     exp_miss = (exp_miss < 15) ? exp_miss + 1 : 15;
  endtask

  // One request end to end: predict, drive, serve memory after lat cycles, score response
  task automatic do_req(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                        input int lat, input bit poke);
    logic          e_hit, exp_mem, mem_seen, acked, stable, done;
    logic [DW-1:0] e_rd;
    logic [AW-1:0] snap_addr;
    logic [DW-1:0] snap_wdata;
    logic          snap_wr;
    int            cyc, waited;
    exp_t          e;
    model_access(wr, a, wd, e_hit, e_rd);
    sb_q.push_back('{rdata: e_rd, hit: e_hit});
    exp_mem = wr || !e_hit;
    @(negedge clk);
    check_val("ready_idle", req_ready, 1);
    req_valid = 1'b1; req_wr = wr; req_addr = a; req_wdata = wd;
    @(negedge clk);
    req_valid = 1'b0;
    cyc = 1; waited = 0; mem_seen = 0; acked = 0; stable = 1; done = 0;
    snap_addr = '0; snap_wdata = '0; snap_wr = 1'b0;
    while (!done && cyc < 200) begin
      mem_ack = 1'b0;
      if (resp_valid) begin
        done = 1;
        if (sb_q.size() == 0) check_val("sb_empty", 1, 0);
        else begin
          e = sb_q.pop_front();
          check_val("rdata", resp_rdata, e.rdata);
          check_val("hit", resp_hit, e.hit);
        end
        check_val("latency", cyc, exp_mem ? 2 + lat : 2);
        check_val("hit_count", hit_count, exp_hits);
        check_val("miss_count", miss_count, exp_miss);
      end else if (mem_req && !acked) begin
        if (!mem_seen) begin
          mem_seen = 1;
          check_val("mem_wr", mem_wr, wr);
          check_val("mem_addr", mem_addr, a);
          if (wr) check_val("mem_wdata", mem_wdata, wd);
          snap_addr = mem_addr; snap_wr = mem_wr; snap_wdata = mem_wdata;
        end else if (mem_addr !== snap_addr || mem_wr !== snap_wr || mem_wdata !== snap_wdata) begin
          stable = 0;
        end
        if (req_ready !== 1'b0) stable = 0;
        if (poke && waited == 3) begin
          req_valid = 1'b1; req_wr = 1'b0; req_addr = a + 32'h100;
        end else begin
          req_valid = 1'b0;
        end
        if (waited == lat - 1) begin
          mem_ack = 1'b1; mem_rdata = mem_read(a); acked = 1;
        end
        waited++;
      end
      if (!done) begin
        @(negedge clk);
        cyc++;
      end
    end
    mem_ack = 1'b0;
    if (!done) check_val("resp_timeout", 0, 1);
    check_val("mem_traffic", mem_seen, exp_mem);
    if (mem_seen) check_val("mem_stable", stable, 1);
    @(negedge clk);
    check_val("resp_one_cycle", resp_valid, 0);
    check_val("ready_after", req_ready, 1);
    if (poke) begin
      repeat (4) begin
        @(negedge clk);
        check_val("no_extra_resp", resp_valid, 0);
      end
    end
  endtask

  // Abandon a read miss with a reset while the memory read is outstanding
  task automatic reset_mid_miss(input logic [AW-1:0] a);
    int pulses = 0;
    @(negedge clk);
    req_valid = 1'b1; req_wr = 1'b0; req_addr = a;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    check_val("mid_mem_req", mem_req, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    check_val("rst_mem_req", mem_req, 0);
    check_val("rst_ready", req_ready, 1);
    check_val("rst_resp", resp_valid, 0);
    repeat (8) begin
      @(negedge clk);
      if (resp_valid) pulses++;
    end
    check_val("rst_no_pulse", pulses, 0);
    check_val("rst_hits", hit_count, 0);
    check_val("rst_miss", miss_count, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    mem_model[32'h40] = 32'hDEAD_BEEF;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check_val("r_ready", req_ready, 1);
    check_val("r_resp_valid", resp_valid, 0);
    check_val("r_resp_hit", resp_hit, 0);
    check_val("r_resp_rdata", resp_rdata, 0);
    check_val("r_mem_req", mem_req, 0);
    check_val("r_mem_wr", mem_wr, 0);
    check_val("r_mem_addr", mem_addr, 0);
    check_val("r_mem_wdata", mem_wdata, 0);
    check_val("r_hits", hit_count, 0);
    check_val("r_miss", miss_count, 0);

    // cold read then reread
    do_req(1'b0, 32'h40, 32'h0, 1, 1'b0);
    do_req(1'b0, 32'h40, 32'h0, 1, 1'b0);
    check_val("cold_hits", hit_count, 1);
    check_val("cold_miss", miss_count, 1);

    // write-through / write-allocate
    do_req(1'b1, 32'h05, 32'h11, 2, 1'b0);
    do_req(1'b0, 32'h05, 32'h0, 1, 1'b0);
    do_req(1'b1, 32'h05, 32'h22, 3, 1'b0);
    do_req(1'b0, 32'h05, 32'h0, 1, 1'b0);

    // LRU in set 3
    for (int i = 0; i < 4; i++) do_req(1'b0, 32'h03 + 32'h10 * i, 32'h0, 1 + i, 1'b0);
    do_req(1'b0, 32'h03, 32'h0, 1, 1'b0);
    do_req(1'b0, 32'h43, 32'h0, 2, 1'b0);
    do_req(1'b0, 32'h13, 32'h0, 1, 1'b0);
    do_req(1'b0, 32'h03, 32'h0, 1, 1'b0);

    // slow memory with an ignored request pulse during the wait
    do_req(1'b0, 32'h77, 32'h0, 10, 1'b1);
    do_req(1'b1, 32'h78, 32'hCAFE_0001, 10, 1'b1);

    // reset during an outstanding miss, then the earlier line is gone
    reset_mid_miss(32'h99);
    do_req(1'b0, 32'h40, 32'h0, 1, 1'b0);

    // hit counter saturation
    for (int i = 0; i < 17; i++) do_req(1'b0, 32'h40, 32'h0, 1, 1'b0);
    check_val("sat_hits", hit_count, 4'hF);
    check_val("sat_miss", miss_count, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
